// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: control-bit positions, the zero register
// and the default datapath widths.
package mips_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // Bit positions inside the 2-bit WB control field carried by MEM/WB.
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_mux.sv
// Write-back value select: load data when MemtoReg is set, ALU result otherwise.
// Kept standalone so the forwarding unit can reuse the same selection.
module wb_mux #(
    parameter int DATA_W = 32
) (
    input  logic              mem_to_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu_data,
    output logic [DATA_W-1:0] wb_data
);

    assign wb_data = mem_to_reg ? mem_data : alu_data;

endmodule

// File: rtl/wb_reg_file.sv
// MIPS write-back stage and 32-entry register file with two combinational read
// ports and same-cycle write-to-read bypass; r0 is hardwired to zero.
module wb_reg_file
    import mips_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        control_wb,
    input  logic [DATA_W-1:0] Read_data,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [ADDR_W-1:0] Write_reg,
    input  logic [ADDR_W-1:0] Read_reg1,
    input  logic [ADDR_W-1:0] Read_reg2,
    output logic [DATA_W-1:0] Read_data1,
    output logic [DATA_W-1:0] Read_data2,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_write
);

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] regs [NUM_REGS];

    wb_mux #(
        .DATA_W (DATA_W)
    ) u_wb_mux (
        .mem_to_reg (control_wb[WB_MEMTOREG]),
        .mem_data   (Read_data),
        .alu_data   (ALU_result),
        .wb_data    (wb_data)
    );

    assign wb_write = control_wb[WB_REGWRITE] && (Write_reg != ZERO_IDX);

    // NOTE: the whole array is cleared by the async reset, so it must stay a
    // flop array; a RAM macro cannot be reset and would leave stale contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_write) begin
            regs[Write_reg] <= wb_data;
        end
    end

    // Bypass takes priority over storage so ID sees the value being written
    // this cycle; r0 is forced to zero ahead of both.
    // NOTE: outputs get a default first so no path through the block leaves
    // them unassigned, which would otherwise infer a latch.
    always_comb begin
        Read_data1 = '0;
        if (Read_reg1 != ZERO_IDX) begin
            if (wb_write && (Write_reg == Read_reg1)) begin
                Read_data1 = wb_data;
            end else begin
                Read_data1 = regs[Read_reg1];
            end
        end
    end

    always_comb begin
        Read_data2 = '0;
        if (Read_reg2 != ZERO_IDX) begin
            if (wb_write && (Write_reg == Read_reg2)) begin
                Read_data2 = wb_data;
            end else begin
                Read_data2 = regs[Read_reg2];
            end
        end
    end

endmodule
